uart_tx_engine: RTL



---
 rtl/uart_tx_engine.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit engine pulling bytes from a standard-latency FIFO
module uart_tx_engine #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       empty,
    output logic       re,
    output logic       dout,
    output logic       busy,
    output logic       done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_PARITY = 3'd5;
    localparam logic [2:0] S_STOP   = 3'd6;

    logic [2:0]    state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          par_acc;
    logic          bit_end;
    logic          stop_last;

    assign bit_end = (baud == BAUD_LAST);
    // bit_idx wraps to 0 after the eighth data bit, so it doubles as the stop-cell counter
    assign stop_last = (STOP_BITS == 2) ? bit_idx[0] : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            par_acc <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    baud <= '0;
                    if (!empty) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    shift   <= din;
                    par_acc <= 1'b0;
                    baud    <= '0;
                    bit_idx <= 3'd0;
                    state   <= S_START;
                end
                S_START: begin
                    if (bit_end) begin
                        baud    <= '0;
                        bit_idx <= 3'd0;
                        state   <= S_DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud    <= '0;
                        shift   <= {1'b0, shift[7:1]};
                        par_acc <= par_acc ^ shift[0];
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        baud  <= '0;
                        state <= S_STOP;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (stop_last) begin
                            bit_idx <= 3'd0;
                            state   <= S_IDLE;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state so async reset forces the line idle at once
    always_comb begin
        dout = 1'b1;
        case (state)
            S_START:  dout = 1'b0;
            S_DATA:   dout = shift[0];
            S_PARITY: dout = (PARITY == 2) ? ~par_acc : par_acc;
            default:  dout = 1'b1;
        endcase
    end

    assign re   = (state == S_FETCH) && !empty;
    assign busy = (state != S_IDLE);
    assign done = (state == S_STOP) && bit_end && stop_last;

endmodule
